alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that reuses the shared 16-bit ALU as its only adder/subtractor.
- Accepts a start command with two operands and drives the ALU control and operand ports one iteration per cycle.
- Shifts and accumulates internally; returns a 2*WIDTH product, or a quotient/remainder pair.
- Sits beside the execute stage; the decoder stalls the pipeline while busy=1.

Parameters:
- WIDTH, 16, operand width; iteration count = WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  command strobe; accepted only in IDLE.
- op  input  2  op[0]: 0=MUL, 1=DIV; op[1]: signed select (see Optional Feature).
- a  input  WIDTH  multiplicand / dividend; sampled on the accepting edge.
- b  input  WIDTH  multiplier / divisor; sampled on the accepting edge.
- busy  output  1  high from the accepting edge until the DONE state.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- div0  output  1  set with done when DIV has b==0; cleared on the next accepted start.
- res_hi  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- res_lo  output  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- alu_InA  output  WIDTH  ALU operand A.
- alu_InB  output  WIDTH  ALU operand B.
- alu_Cin  output  1  ALU carry-in.
- alu_Oper  output  4  ALU operation; fixed at 4'b0100 (add).
- alu_invA  output  1  fixed at 0.
- alu_invB  output  1  0 = add, 1 = subtract.
- alu_sign  output  1  fixed at 0 (unsigned, so Cfl = raw carry).
- alu_Out  input  WIDTH  ALU result, combinational within the same cycle.
- alu_Cfl  input  1  ALU carry-out.

Behaviour:
- Reset (async): state=IDLE; busy, done, div0=0; res_hi, res_lo=0; counter=0; alu_InA, alu_InB, alu_Cin, alu_invB=0.
- FSM: IDLE -> RUN on start. RUN -> DONE after WIDTH iterations. DONE -> IDLE unconditionally.
- IDLE -> DONE directly when the op is DIV and b==0.
- Operand/result registers:
  - acc is WIDTH+1 bits.
  - MUL: lo = multiplier, acc = 0, md = a.
  - DIV: lo = dividend, acc = 0, md = b.
- MUL iteration:
  - ALU computes acc[W-1:0] + md with invB=0, Cin=0.
  - If lo[0]=1: {acc, lo} <= {alu_Cfl, alu_Out, lo} >> 1.
  - Else: {acc, lo} <= {1'b0, acc[W-1:0], lo} >> 1.
- DIV iteration (restoring):
  - t = {acc[W-1:0], lo[W-1]}.
  - ALU computes t[W-1:0] - md with invB=1, Cin=1.
  - ok = alu_Cfl | t[W].
  - If ok: acc <= alu_Out, else acc <= t[W-1:0].
  - lo <= {lo[W-2:0], ok}.
- Counter increments each RUN cycle; the last iteration is at count==WIDTH-1.
- Latency: start accepted at edge T; done=1 in the cycle after edge T+WIDTH (17 cycles for WIDTH=16).
- busy is high during RUN and low in DONE.
- Divide by zero: done pulses in the cycle after the accepting edge; res_lo=all ones, res_hi=a, div0=1.
- Results hold until the next accepted start.
- start is ignored while busy. start asserted during the DONE cycle is also ignored.
- Outside RUN, the ALU operands are driven to 0.
- Async reset mid-operation aborts immediately: no done pulse, results return to 0.

Optional Feature:
- Macro: ALU_MULDIV_SIGNED_EN.
- Defined:
  - op[1]=1 selects signed two's-complement MUL/DIV.
  - A PREP state converts operands to magnitudes: one cycle per negated operand, each negation done on the ALU as 0 + ~x + 1.
  - A FIXUP state negates the results:
    - product when sign(a)^sign(b);
    - quotient when sign(a)^sign(b);
    - remainder when sign(a).
  - FIXUP uses two ALU cycles for the 32-bit product (carry chained via alu_Cfl).
  - Signed latency = unsigned latency + up to 4 cycles; busy stays high throughout.
  - Signed div0 returns res_lo=all ones, res_hi=a.
- Undefined: op[1] is ignored, all operations are unsigned, and the PREP/FIXUP states are absent.

Test Plan:
- Reset, then MUL a=0x1234, b=0x0010 -> done after 17 cycles; res_hi=0x0001, res_lo=0x2340, div0=0.
- MUL a=0xFFFF, b=0xFFFF -> res_hi=0xFFFE, res_lo=0x0001; busy high for exactly 16 cycles.
- DIV a=100, b=7 -> res_lo=0x000E, res_hi=0x0002. Then DIV a=0x8001, b=0x0001 -> res_lo=0x8001, res_hi=0.
- DIV a=0x0042, b=0 -> done in the cycle after start; div0=1, res_lo=0xFFFF, res_hi=0x0042.
- Start MUL, pulse start again at cycle 5 with different operands -> second start ignored, first result returned. Assert rst at cycle 8 of a second op -> busy=0, no done, outputs 0.
- With ALU_MULDIV_SIGNED_EN: MUL op=2'b10, a=-6, b=7 -> {res_hi,res_lo}=0xFFFFFFD6. DIV op=2'b11, a=-7, b=2 -> res_lo=0xFFFD, res_hi=0xFFFF.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Multi-cycle multiply/divide sequencer. It has no adder of its own. Each
// iteration drives the shared 16-bit ALU and uses its combinational result in
// the same cycle. MUL is shift-and-add and produces a 2*WIDTH product. DIV is
// restoring division and produces a quotient and a remainder. The pipeline
// stalls while o_busy is high.
//
// Configuration macro: ALU_MULDIV_SIGNED_EN
//   When it is defined, op[1]=1 selects signed two's-complement operation.
//   The PREP state turns the operands into magnitudes. The FIXUP state
//   negates the results. Both states do their negations on the ALU.
//   When it is undefined, op[1] is ignored and all operations are unsigned.
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_start               command strobe, accepted only in IDLE
//   i_op                  [0]: 0=MUL 1=DIV, [1]: signed select
//   i_a, i_b              multiplicand/dividend and multiplier/divisor
//   o_busy                high from the accepting edge until DONE
//   o_done                one-cycle completion pulse
//   o_div0                set with done when a DIV had a zero divisor
//   o_res_hi, o_res_lo    MUL: product high/low, DIV: remainder/quotient
//   o_alu_*               drive for the shared ALU (always an add)
//   i_alu_Out, i_alu_Cfl  ALU sum and raw carry-out
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo,
    output logic [WIDTH-1:0] o_alu_InA,
    output logic [WIDTH-1:0] o_alu_InB,
    output logic             o_alu_Cin,
    output logic [3:0]       o_alu_Oper,
    output logic             o_alu_invA,
    output logic             o_alu_invB,
    output logic             o_alu_sign,
    input  logic [WIDTH-1:0] i_alu_Out,
    input  logic             i_alu_Cfl
);

`ifdef ALU_MULDIV_SIGNED_EN
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_PREP, S_FIXUP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t           r_state, w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_md;
    logic             r_isDiv;
    logic             r_div0;
    logic [WIDTH:0]   w_divT;
    logic             w_divOk;
    logic             w_divZero;
    logic             w_lastIter;

`ifdef ALU_MULDIV_SIGNED_EN
    // Pending negations: operands in PREP, result halves in FIXUP.
    logic r_prepLo, r_prepMd, r_fixLo, r_fixHi, r_carry;
    logic w_sA, w_sB;
    assign w_sA = i_op[1] & i_a[WIDTH-1];
    assign w_sB = i_op[1] & i_b[WIDTH-1];
`else
    logic w_unusedOpSigned;
    assign w_unusedOpSigned = i_op[1];
`endif

    // The restoring-division trial value is the partial remainder shifted
    // left with the next dividend bit. Its top bit means the subtraction
    // cannot borrow, whatever the ALU carry says.
    assign w_divT     = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_divOk    = i_alu_Cfl | w_divT[WIDTH];
    assign w_divZero  = i_op[0] && (i_b == '0);
    assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

    assign o_alu_Oper = 4'b0100;
    assign o_alu_invA = 1'b0;
    assign o_alu_sign = 1'b0;
    assign o_div0     = r_div0;
    assign o_res_hi   = r_acc[WIDTH-1:0];
    assign o_res_lo   = r_lo;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic. A zero divisor skips the iterations entirely. A start
    // seen in DONE is dropped because DONE always returns to IDLE first.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_divZero)       w_nextState = S_DONE;
`ifdef ALU_MULDIV_SIGNED_EN
                    else if (w_sA | w_sB) w_nextState = S_PREP;
`endif
                    else                 w_nextState = S_RUN;
                end
            end
`ifdef ALU_MULDIV_SIGNED_EN
            S_PREP:  w_nextState = (r_prepLo & r_prepMd) ? S_PREP : S_RUN;
            S_FIXUP: w_nextState = (r_fixLo & r_fixHi) ? S_FIXUP : S_DONE;
`endif
            S_RUN: begin
                if (w_lastIter) begin
`ifdef ALU_MULDIV_SIGNED_EN
                    w_nextState = (r_fixLo | r_fixHi) ? S_FIXUP : S_DONE;
`else
                    w_nextState = S_DONE;
`endif
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output logic: status flags and ALU drive. Every negation is computed
    // as 0 + ~x + 1. The high half of a product negation chains the carry
    // from the low half.
    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_alu_InA  = '0;
        o_alu_InB  = '0;
        o_alu_Cin  = 1'b0;
        o_alu_invB = 1'b0;
        case (r_state)
            S_RUN: begin
                o_busy    = 1'b1;
                o_alu_InB = r_md;
                if (r_isDiv) begin
                    o_alu_InA  = w_divT[WIDTH-1:0];
                    o_alu_invB = 1'b1;
                    o_alu_Cin  = 1'b1;
                end else begin
                    o_alu_InA = r_acc[WIDTH-1:0];
                end
            end
`ifdef ALU_MULDIV_SIGNED_EN
            S_PREP: begin
                o_busy     = 1'b1;
                o_alu_InB  = r_prepLo ? r_lo : r_md;
                o_alu_invB = 1'b1;
                o_alu_Cin  = 1'b1;
            end
            S_FIXUP: begin
                o_busy     = 1'b1;
                o_alu_InB  = r_fixLo ? r_lo : r_acc[WIDTH-1:0];
                o_alu_invB = 1'b1;
                o_alu_Cin  = r_fixLo | r_isDiv | r_carry;
            end
`endif
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The operand and result registers are shared. The result
    // outputs are the iteration registers themselves, so they hold from DONE
    // until the next accepted start reloads them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_md    <= '0;
            r_isDiv <= 1'b0;
            r_div0  <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
            r_prepLo <= 1'b0;
            r_prepMd <= 1'b0;
            r_fixLo  <= 1'b0;
            r_fixHi  <= 1'b0;
            r_carry  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_isDiv <= i_op[0];
                        r_div0  <= w_divZero;
                        if (w_divZero) begin
                            r_acc <= {1'b0, i_a};
                            r_lo  <= '1;
                        end else begin
                            r_acc <= '0;
                            r_lo  <= i_op[0] ? i_a : i_b;
                            r_md  <= i_op[0] ? i_b : i_a;
                        end
`ifdef ALU_MULDIV_SIGNED_EN
                        r_prepLo <= i_op[0] ? w_sA : w_sB;
                        r_prepMd <= i_op[0] ? w_sB : w_sA;
                        r_fixLo  <= w_sA ^ w_sB;
                        r_fixHi  <= i_op[0] ? w_sA : (w_sA ^ w_sB);
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_isDiv) begin
                        r_acc <= w_divOk ? {1'b0, i_alu_Out} : {1'b0, w_divT[WIDTH-1:0]};
                        r_lo  <= {r_lo[WIDTH-2:0], w_divOk};
                    end else if (r_lo[0]) begin
                        {r_acc, r_lo} <= {i_alu_Cfl, i_alu_Out, r_lo} >> 1;
                    end else begin
                        // The top bit of acc is always 0 between multiply steps.
                        {r_acc, r_lo} <= {r_acc, r_lo} >> 1;
                    end
                end
`ifdef ALU_MULDIV_SIGNED_EN
                S_PREP: begin
                    if (r_prepLo) begin
                        r_lo     <= i_alu_Out;
                        r_prepLo <= 1'b0;
                    end else begin
                        r_md     <= i_alu_Out;
                        r_prepMd <= 1'b0;
                    end
                end
                S_FIXUP: begin
                    if (r_fixLo) begin
                        r_lo    <= i_alu_Out;
                        r_carry <= i_alu_Cfl;
                        r_fixLo <= 1'b0;
                    end else begin
                        r_acc   <= {1'b0, i_alu_Out};
                        r_fixHi <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Self-checking bench for alu_muldiv_seq. The bench supplies the shared ALU
// as a combinational adder. A behavioural model holds the expected status
// flags and results, computed with plain arithmetic and a latency countdown.
// One compare process checks the DUT against that model on every falling
// edge. The directed operations also check hand-computed literal results and
// latencies.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

    logic        clk, rst, start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, div0;
    logic [15:0] resHi, resLo;
    logic [15:0] aluInA, aluInB, aluOut;
    logic        aluCin, aluInvA, aluInvB, aluSign, aluCfl;
    logic [3:0]  aluOper;
    logic [16:0] aluSum;

    int checks = 0;
    int errors = 0;

    // Expected state from the behavioural model.
    logic        mBusy = 1'b0, mDone = 1'b0, mDiv0 = 1'b0, mIsDiv = 1'b0;
    logic [15:0] mHi = '0, mLo = '0;
    logic [31:0] mPend = '0;
    int          mLeft = 0;

    alu_muldiv_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_div0(div0),
        .o_res_hi(resHi), .o_res_lo(resLo),
        .o_alu_InA(aluInA), .o_alu_InB(aluInB), .o_alu_Cin(aluCin),
        .o_alu_Oper(aluOper), .o_alu_invA(aluInvA), .o_alu_invB(aluInvB),
        .o_alu_sign(aluSign), .i_alu_Out(aluOut), .i_alu_Cfl(aluCfl)
    );

    // Shared ALU: an add with optional operand inversion and carry-in.
    assign aluSum = {1'b0, aluInA ^ {16{aluInvA}}} + {1'b0, aluInB ^ {16{aluInvB}}} + 17'(aluCin);
    assign aluOut = aluSum[15:0];
    assign aluCfl = aluSum[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result from the arithmetic definition: {res_hi, res_lo}.
    function automatic logic [31:0] modelResult(input logic [1:0] opIn, input logic [15:0] aIn, input logic [15:0] bIn);
        bit sgn;
        int sa, sb;
`ifdef ALU_MULDIV_SIGNED_EN
        sgn = opIn[1];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? int'($signed(aIn)) : int'(aIn);
        sb = sgn ? int'($signed(bIn)) : int'(bIn);
        if (!opIn[0]) return 32'(sa * sb);
        if (bIn == 16'h0) return {aIn, 16'hFFFF};
        return {16'(sa % sb), 16'(sa / sb)};
    endfunction

    // Number of clock edges after the accepting edge until done is raised.
    function automatic int modelLatency(input logic [1:0] opIn, input logic [15:0] aIn, input logic [15:0] bIn);
        int extra;
        extra = 0;
        if (opIn[0] && bIn == 16'h0) return 0;
`ifdef ALU_MULDIV_SIGNED_EN
        begin
            bit sA, sB;
            sA = opIn[1] & aIn[15];
            sB = opIn[1] & bIn[15];
            extra = int'(sA) + int'(sB);
            if (!opIn[0]) extra += (sA ^ sB) ? 2 : 0;
            else          extra += int'(sA ^ sB) + int'(sA);
        end
`endif
        return 16 + extra;
    endfunction

    // Behavioural model: one command at a time, a countdown to done, and a
    // one-cycle done during which a new start is dropped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy <= 1'b0; mDone <= 1'b0; mDiv0 <= 1'b0; mIsDiv <= 1'b0;
            mHi <= '0; mLo <= '0; mLeft <= 0; mPend <= '0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (mBusy) begin
            if (mLeft == 1) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
                {mHi, mLo} <= mPend;
            end else begin
                mLeft <= mLeft - 1;
            end
        end else if (start) begin
            mDiv0  <= op[0] && (b == 16'h0);
            mIsDiv <= op[0];
            if (modelLatency(op, a, b) == 0) begin
                mDone <= 1'b1;
                {mHi, mLo} <= modelResult(op, a, b);
            end else begin
                mBusy <= 1'b1;
                mLeft <= modelLatency(op, a, b);
                mPend <= modelResult(op, a, b);
            end
        end
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model. Results are compared only
    // when no command is in flight.
    always @(negedge clk) begin
        compare("busy", 32'(busy), 32'(mBusy));
        compare("done", 32'(done), 32'(mDone));
        compare("div0", 32'(div0), 32'(mDiv0));
        compare("aluOper", 32'(aluOper), 32'h4);
        compare("aluInvA", 32'(aluInvA), 32'h0);
        compare("aluSign", 32'(aluSign), 32'h0);
        if (!mBusy) begin
            compare("resHi", 32'(resHi), 32'(mHi));
            compare("resLo", 32'(resLo), 32'(mLo));
            compare("aluInAIdle", 32'(aluInA), 32'h0);
            compare("aluInBIdle", 32'(aluInB), 32'h0);
            compare("aluCinIdle", 32'(aluCin), 32'h0);
            compare("aluInvBIdle", 32'(aluInvB), 32'h0);
        end
`ifndef ALU_MULDIV_SIGNED_EN
        else begin
            compare("aluInvBRun", 32'(aluInvB), 32'(mIsDiv));
            compare("aluCinRun", 32'(aluCin), 32'(mIsDiv));
        end
`endif
    end

    task automatic applyStimulus(input logic [1:0] opIn, input logic [15:0] aIn, input logic [15:0] bIn);
        @(posedge clk); #1;
        start = 1'b1; op = opIn; a = aIn; b = bIn;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts falling edges after the accepting edge until done is seen.
    task automatic waitDone(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busyCnt++;
        end while (!done && lat < 64);
        compare("doneSeen", 32'(done), 32'h1);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expHi, input logic [15:0] expLo,
                               input logic expDiv0, input int lat, input int expLat,
                               input int busyCnt, input int expBusy);
        compare($sformatf("%s.resHi", name), 32'(resHi), 32'(expHi));
        compare($sformatf("%s.resLo", name), 32'(resLo), 32'(expLo));
        compare($sformatf("%s.div0", name), 32'(div0), 32'(expDiv0));
        compare($sformatf("%s.latency", name), 32'(lat), 32'(expLat));
        compare($sformatf("%s.busyCycles", name), 32'(busyCnt), 32'(expBusy));
    endtask

    task automatic runOp(input string name, input logic [1:0] opIn, input logic [15:0] aIn, input logic [15:0] bIn,
                         input logic [15:0] expHi, input logic [15:0] expLo, input logic expDiv0, input int expLat);
        int lat, busyCnt;
        applyStimulus(opIn, aIn, bIn);
        waitDone(lat, busyCnt);
        checkOutput(name, expHi, expLo, expDiv0, lat, expLat, busyCnt, (expLat == 1) ? 0 : expLat - 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, busyCnt;
        rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare("reset.busy", 32'(busy), 32'h0);
        compare("reset.done", 32'(done), 32'h0);
        compare("reset.resHi", 32'(resHi), 32'h0);
        compare("reset.resLo", 32'(resLo), 32'h0);

        runOp("mul1234x10", 2'b00, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17);
        runOp("mulMax",     2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
        runOp("div100by7",  2'b01, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 17);
        runOp("div8001by1", 2'b01, 16'h8001, 16'h0001, 16'h0000, 16'h8001, 1'b0, 17);
        runOp("divByZero",  2'b01, 16'h0042, 16'h0000, 16'h0042, 16'hFFFF, 1'b1, 1);
        runOp("divBig",     2'b01, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17);

        // A second start while busy must be dropped.
        applyStimulus(2'b00, 16'h0003, 16'h0005);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; op = 2'b01; a = 16'h7777; b = 16'h0000;
        @(posedge clk); #1; start = 1'b0;
        waitDone(lat, busyCnt);
        checkOutput("ignoredStart", 16'h0000, 16'h000F, 1'b0, lat, 12, busyCnt, 11);

        // A start during the done cycle must also be dropped.
        start = 1'b1; op = 2'b00; a = 16'h0002; b = 16'h0002;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        compare("doneStart.busy", 32'(busy), 32'h0);
        compare("doneStart.resLo", 32'(resLo), 32'h000F);

        // Reset in the middle of an operation aborts it at once.
        applyStimulus(2'b00, 16'h00FF, 16'h0101);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        compare("abort.busy", 32'(busy), 32'h0);
        compare("abort.done", 32'(done), 32'h0);
        compare("abort.resHi", 32'(resHi), 32'h0);
        compare("abort.resLo", 32'(resLo), 32'h0);
        compare("abort.div0", 32'(div0), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);

        runOp("afterAbort", 2'b00, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 17);

`ifdef ALU_MULDIV_SIGNED_EN
        runOp("sMulNeg6x7",  2'b10, 16'hFFFA, 16'h0007, 16'hFFFF, 16'hFFD6, 1'b0, 20);
        runOp("sDivNeg7by2", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 20);
        runOp("sDivByZero",  2'b11, 16'hFFF0, 16'h0000, 16'hFFF0, 16'hFFFF, 1'b1, 1);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
